// File: rtl/spi_axi_pkg.sv
// Register map, field positions and AXI response codes shared by spi_axi_slave.
package spi_axi_pkg;

    // Register index is byte address bits [4:2].
    typedef enum logic [2:0] {
        RegCtrl   = 3'd0,
        RegStatus = 3'd1,
        RegTiming = 3'd2,
        RegTxdata = 3'd3,
        RegRxdata = 3'd4,
        RegIrqen  = 3'd5
    } reg_idx_e;

    localparam int unsigned CtrlStartBit   = 0;
    localparam int unsigned CtrlModeLsb    = 1;
    localparam int unsigned CtrlSpeedLsb   = 3;
    localparam int unsigned CtrlLenLsb     = 5;

    localparam int unsigned StatusBusyBit  = 0;
    localparam int unsigned StatusDoneBit  = 1;

    localparam int unsigned TimingIfgLsb   = 0;
    localparam int unsigned TimingCsSckLsb = 8;
    localparam int unsigned TimingSckCsLsb = 16;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/spi_axi_slave.sv
// AXI4-Lite register front end for an SPI master register stage.
// Defining SPI_IRQ_EN adds the IRQEN register at 0x14 and a registered done interrupt.
module spi_axi_slave
    import spi_axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              GCLK,
    input  logic              NRST,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              start_o,
    input  logic              busy_i,
    output logic [1:0]        spi_mode_o,
    output logic [1:0]        sck_speed_o,
    output logic [1:0]        word_len_o,
    output logic [7:0]        IFG_o,
    output logic [7:0]        CS_SCK_o,
    output logic [7:0]        SCK_CS_o,
    output logic [31:0]       mosi_data_o,
    input  logic [31:0]       miso_data_i,
    output logic              irq_o
);

    logic        awready_q, awready_d, bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        start_q, start_d, pending_q, pending_d;
    logic        busy_prev_q, done_q, done_d;
    logic [1:0]  spi_mode_q, spi_mode_d, sck_speed_q, sck_speed_d, word_len_q, word_len_d;
    logic [23:0] timing_q, timing_d;
    logic [31:0] txdata_q, txdata_d, rxdata_q, rxdata_d;
`ifdef SPI_IRQ_EN
    logic        irqen_q, irqen_d, irq_q;
`endif

    reg_idx_e    aw_idx, ar_idx;
    logic        wr_fire, rd_fire, eff_busy, busy_fall, done_clr;
    logic [1:0]  wr_resp, rd_resp;
    logic [31:0] rd_val;
    logic        unused_addr;

    assign aw_idx      = reg_idx_e'(s_axi_awaddr[4:2]);
    assign ar_idx      = reg_idx_e'(s_axi_araddr[4:2]);
    assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

    assign wr_fire   = awready_q & s_axi_awvalid & s_axi_wvalid;
    assign rd_fire   = arready_q & s_axi_arvalid;
    assign eff_busy  = busy_i | pending_q;
    assign busy_fall = busy_prev_q & ~busy_i;

    // Write channel and register updates.
    always_comb begin
        awready_d   = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
        bvalid_d    = bvalid_q & ~s_axi_bready;
        bresp_d     = bresp_q;
        spi_mode_d  = spi_mode_q;
        sck_speed_d = sck_speed_q;
        word_len_d  = word_len_q;
        timing_d    = timing_q;
        txdata_d    = txdata_q;
        start_d     = 1'b0;
        done_clr    = 1'b0;
        wr_resp     = RespOkay;
`ifdef SPI_IRQ_EN
        irqen_d     = irqen_q;
`endif
        if (wr_fire) begin
            case (aw_idx)
                RegCtrl: begin
                    if (eff_busy) begin
                        wr_resp = RespSlverr;
                    end else if (s_axi_wstrb[0]) begin
                        spi_mode_d  = s_axi_wdata[CtrlModeLsb +: 2];
                        sck_speed_d = s_axi_wdata[CtrlSpeedLsb +: 2];
                        word_len_d  = s_axi_wdata[CtrlLenLsb +: 2];
                        start_d     = s_axi_wdata[CtrlStartBit];
                    end
                end
                RegStatus: done_clr = s_axi_wstrb[0] & s_axi_wdata[StatusDoneBit];
                RegTiming: begin
                    if (eff_busy) begin
                        wr_resp = RespSlverr;
                    end else begin
                        for (int i = 0; i < 3; i++) begin
                            if (s_axi_wstrb[i]) timing_d[8*i +: 8] = s_axi_wdata[8*i +: 8];
                        end
                    end
                end
                RegTxdata: begin
                    if (eff_busy) wr_resp = RespSlverr;
                    else txdata_d = apply_strb(txdata_q, s_axi_wdata, s_axi_wstrb);
                end
                RegRxdata: ;
`ifdef SPI_IRQ_EN
                RegIrqen: if (s_axi_wstrb[0]) irqen_d = s_axi_wdata[0];
`endif
                default: wr_resp = RespSlverr;
            endcase
            bvalid_d = 1'b1;
            bresp_d  = wr_resp;
        end
    end

    // Hardware done set takes priority over a simultaneous W1C.
    assign pending_d = start_d | (pending_q & ~busy_i);
    assign done_d    = busy_fall | (done_q & ~done_clr);
    assign rxdata_d  = busy_fall ? miso_data_i : rxdata_q;

    // Read channel; rdata is sampled from pre-write register values.
    always_comb begin
        rd_val  = '0;
        rd_resp = RespOkay;
        case (ar_idx)
            RegCtrl:   rd_val[6:1] = {word_len_q, sck_speed_q, spi_mode_q};
            RegStatus: begin
                rd_val[StatusDoneBit] = done_q;
                rd_val[StatusBusyBit] = eff_busy;
            end
            RegTiming: rd_val[23:0] = timing_q;
            RegTxdata: rd_val = txdata_q;
            RegRxdata: rd_val = rxdata_q;
`ifdef SPI_IRQ_EN
            RegIrqen:  rd_val[0] = irqen_q;
`endif
            default:   rd_resp = RespSlverr;
        endcase
        arready_d = s_axi_arvalid & ~rvalid_q & ~arready_q;
        rvalid_d  = rd_fire | (rvalid_q & ~s_axi_rready);
        rdata_d   = rd_fire ? rd_val : rdata_q;
        rresp_d   = rd_fire ? rd_resp : rresp_q;
    end

    always_ff @(posedge GCLK or negedge NRST) begin
        if (!NRST) begin
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rresp_q     <= 2'b00;
            rdata_q     <= '0;
            start_q     <= 1'b0;
            pending_q   <= 1'b0;
            busy_prev_q <= 1'b0;
            done_q      <= 1'b0;
            spi_mode_q  <= 2'b00;
            sck_speed_q <= 2'b00;
            word_len_q  <= 2'b00;
            timing_q    <= '0;
            txdata_q    <= '0;
            rxdata_q    <= '0;
        end else begin
            awready_q   <= awready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            start_q     <= start_d;
            pending_q   <= pending_d;
            busy_prev_q <= busy_i;
            done_q      <= done_d;
            spi_mode_q  <= spi_mode_d;
            sck_speed_q <= sck_speed_d;
            word_len_q  <= word_len_d;
            timing_q    <= timing_d;
            txdata_q    <= txdata_d;
            rxdata_q    <= rxdata_d;
        end
    end

`ifdef SPI_IRQ_EN
    always_ff @(posedge GCLK or negedge NRST) begin
        if (!NRST) begin
            irqen_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irqen_q <= irqen_d;
            irq_q   <= done_q & irqen_q;
        end
    end
    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign start_o       = start_q;
    assign spi_mode_o    = spi_mode_q;
    assign sck_speed_o   = sck_speed_q;
    assign word_len_o    = word_len_q;
    assign IFG_o         = timing_q[TimingIfgLsb +: 8];
    assign CS_SCK_o      = timing_q[TimingCsSckLsb +: 8];
    assign SCK_CS_o      = timing_q[TimingSckCsLsb +: 8];
    assign mosi_data_o   = txdata_q;

endmodule

// File: doc/spi_axi_slave.md
SPI_AXI_SLAVE -- requirements
Module: spi_axi_slave

Interface
REQ-001 Parameter ADDR_W, default 5, AXI byte-address width; bits [4:2] select the register and bits [1:0] are ignored.
REQ-002 GCLK  input  1  single clock; all flops on rising edge.
REQ-003 NRST  input  1  reset, asynchronous assert, active-low.
REQ-004 s_axi_awaddr/awvalid  input  ADDR_W/1;  s_axi_awready  output  1  -- AXI4-Lite write address.
REQ-005 s_axi_wdata/wstrb/wvalid  input  32/4/1;  s_axi_wready  output  1  -- write data.
REQ-006 s_axi_bresp/bvalid  output  2/1;  s_axi_bready  input  1  -- write response.
REQ-007 s_axi_araddr/arvalid  input  ADDR_W/1;  s_axi_arready  output  1  -- read address.
REQ-008 s_axi_rdata/rresp/rvalid  output  32/2/1;  s_axi_rready  input  1  -- read data.
REQ-009 start_o  output  1  one-cycle transfer request to the downstream SPI register stage.
REQ-010 busy_i  input  1  downstream busy, arrives 2 cycles after start_o.
REQ-011 spi_mode_o/sck_speed_o/word_len_o  output  2/2/2  transfer configuration.
REQ-012 IFG_o/CS_SCK_o/SCK_CS_o  output  8/8/8  timing gaps in SCK periods.
REQ-013 mosi_data_o  output  32  transmit word;  miso_data_i  input  32  received word.
REQ-014 irq_o  output  1  done interrupt (present only with SPI_IRQ_EN).

Function
REQ-015 Register map: 0x00 CTRL {[6:5] word_len, [4:3] sck_speed, [2:1] spi_mode, [0] start W1 self-clearing, reads 0}; 0x04 STATUS {[1] done sticky W1C, [0] busy} RO except done; 0x08 TIMING {[23:16] SCK_CS, [15:8] CS_SCK, [7:0] IFG}; 0x0C TXDATA; 0x10 RXDATA RO; 0x14 IRQEN {[0]}.
REQ-016 Write: awready and wready assert together for exactly one cycle when awvalid, wvalid both high and no response is outstanding; bvalid asserts the next cycle and holds until bready.
REQ-017 Read: arready asserts one cycle when arvalid and no rvalid outstanding; rvalid with rdata asserts the next cycle and holds, data stable, until rready.
REQ-018 Read and write channels operate independently; a same-cycle read of a register being written returns the pre-write value.
REQ-019 wstrb applies per byte to TXDATA and TIMING; CTRL and STATUS use byte 0 only.
REQ-020 Effective busy = busy_i OR pending; pending sets on start_o and clears on the first cycle busy_i is high.
REQ-021 CTRL start=1 while effective busy is low: start_o pulses high one cycle after the write handshake, bresp OKAY.
REQ-022 Any write to CTRL, TIMING or TXDATA while effective busy is high: register unchanged, no start_o, bresp SLVERR (2'b10).
REQ-023 busy_i falling edge (previous 1, current 0): capture miso_data_i into RXDATA and set done in the same cycle.
REQ-024 Done set by hardware wins over a simultaneous W1C of done.
REQ-025 Unmapped address: write ignored with SLVERR; read returns 0 with SLVERR.
REQ-026 Configuration outputs are driven directly from their registers, no combinational path from AXI inputs.

Reset
REQ-027 NRST low: all ready/valid outputs, start_o, irq_o, pending, done, all registers and rdata go to 0 immediately; bresp/rresp 0.
REQ-028 Reset mid-transfer discards the outstanding response; busy_i remains observed after release, but no RXDATA capture or done occurs until busy_i has been seen high again.

Configuration
REQ-029 Macro SPI_IRQ_EN defined: IRQEN register exists and irq_o = done AND IRQEN[0], registered.
REQ-030 Macro SPI_IRQ_EN undefined: irq_o tied 0, 0x14 treated as unmapped.

Structure
REQ-031 Shared package spi_axi_pkg holds register offsets, CTRL/STATUS/TIMING field positions and the OKAY/SLVERR response constants.
REQ-032 No sub-module; single flat module.

Verification
REQ-033 Write 0x08 = 0x00030201 -> OKAY; IFG_o=1, CS_SCK_o=2, SCK_CS_o=3.
REQ-034 Write TXDATA=0xA5A5F00F, then CTRL=0x0000002B -> start_o single pulse; spi_mode=1, sck_speed=1, word_len=1; STATUS reads 0x1.
REQ-035 Second CTRL write before busy_i rises -> SLVERR, no second start_o.
REQ-036 busy_i 1->0 with miso_data_i=0x12345678 -> RXDATA reads 0x12345678, STATUS=0x2; W1C 0x2 -> 0x0.
REQ-037 Read 0x1C -> rdata 0, rresp SLVERR; bready held low 5 cycles -> bvalid and bresp held stable.
REQ-038 With SPI_IRQ_EN, IRQEN=1 and transfer completion -> irq_o high until done cleared; with the macro undefined, irq_o stays 0.
